jesd204b_tx_ctrl: RTL and testbench
===================================

JESD204B_TX_CTRL -- requirements
Module: jesd204b_tx_ctrl

Interface
REQ-001 Parameter LANES, default 4, number of lanes.
REQ-002 Parameter OCTETS, default 4, octets per frame per lane (F); SHALL be even.
REQ-003 Parameter FRAMES, default 32, frames per multiframe (K); range 2..32.
REQ-004 Parameter ILAS_MF, default 4, multiframes in ILAS; range 1..15.
REQ-005 clk  input  1  single clock; one frame per cycle.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 sync_n  input  1  SYNC~ from receiver, asynchronous, low requests resync.
REQ-008 tpl_data  input  LANES*8*OCTETS  transport-layer frame; lane i in [i*8*OCTETS +: 8*OCTETS], octet 0 in the most significant byte.
REQ-009 tpl_ready  output  1  high when tpl_data is being consumed (DATA state).
REQ-010 tx_data  output  LANES*8*OCTETS  lane octets, same packing as tpl_data.
REQ-011 tx_charisk  output  LANES*OCTETS  control-character flags; lane i in [i*OCTETS +: OCTETS], octet 0 at MSB.
REQ-012 link_state  output  2  0=CGS, 1=ILAS, 2=DATA.
REQ-013 lmfc  output  1  one-cycle pulse at frame 0 of each multiframe.

Function
REQ-014 sync_n SHALL pass a 2-flop synchronizer (sync_s) before use; 2-cycle latency.
REQ-015 Frame counter fcnt SHALL run 0..FRAMES-1, incrementing every cycle, wrapping to 0 at FRAMES-1, independent of state.
REQ-016 lmfc SHALL be registered, high for the cycle after fcnt==0.
REQ-017 CGS: all octets on all lanes = 0xBC (K28.5), charisk all ones, tpl_ready 0.
REQ-018 CGS->ILAS when sync_s==1 and fcnt==FRAMES-1; ILAS begins at fcnt==0.
REQ-019 sync_s high then low before the LMFC boundary: remain in CGS.
REQ-020 ILAS: multiframe counter mcnt 0..ILAS_MF-1, incremented when fcnt wraps.
REQ-021 ILAS octet content, per lane identical: frame 0 octet 0 = 0x1C (K28.0, /R/); frame FRAMES-1 octet OCTETS-1 = 0x7C (K28.3, /A/); in mcnt==1, frame 0 octet 1 = 0x9C (K28.4, /Q/); all other octets = (fcnt*OCTETS+octet) mod 256 with charisk 0.
REQ-022 ILAS->DATA when mcnt==ILAS_MF-1 and fcnt==FRAMES-1; DATA begins at fcnt==0.
REQ-023 DATA: tx_data = tpl_data, charisk 0, tpl_ready 1.
REQ-024 ILAS or DATA -> CGS when sync_s is low on two consecutive cycles; transition on the cycle after the second low; mcnt cleared.
REQ-025 A single-cycle sync_s low in ILAS/DATA SHALL be ignored.
REQ-026 Resync (REQ-024) SHALL take priority over ILAS->DATA at the same cycle.
REQ-027 tx_data, tx_charisk, tpl_ready SHALL be registered from current state and fcnt: one-cycle latency, i.e. tpl_data sampled at edge n appears at edge n+1.
REQ-028 link_state SHALL equal the state register (no extra delay).
REQ-029 Any lane/octet outside the above content rules SHALL not occur; no X on outputs after reset.

Reset
REQ-030 rst_n low SHALL immediately clear: state=CGS, fcnt=0, mcnt=0, synchronizer flops=0 (i.e. sync asserted), tx_data=0, tx_charisk=0, tpl_ready=0, lmfc=0.
REQ-031 First registered output after rst_n release SHALL be CGS content (0xBC, charisk all ones).
REQ-032 Reset mid-ILAS or mid-DATA SHALL abort to CGS without completing the multiframe.

Verification (defaults LANES=4, OCTETS=4, FRAMES=32, ILAS_MF=4)
REQ-033 Release reset, hold sync_n=0 200 cycles -> tx_data all 0xBC, tx_charisk 16'hFFFF, link_state 0, lmfc every 32 cycles.
REQ-034 Raise sync_n at fcnt==5 -> link_state 1 from next fcnt==0; per lane first octet 0x1C, octet 3 of frame 31 = 0x7C, frame 0 octet 1 of 2nd multiframe = 0x9C; DATA 128 cycles after ILAS start.
REQ-035 In DATA drive tpl_data = incrementing 128-bit counter -> tx_data equals tpl_data one cycle later, tpl_ready 1, tx_charisk 0.
REQ-036 In DATA pulse sync_n low 1 cycle -> no state change; low 2 cycles -> link_state 0 on cycle after second synchronized low, tx_data 0xBC next cycle.
REQ-037 Raise sync_n then drop it at fcnt==20 -> stays CGS; drop sync_n for 2 cycles ending at final ILAS frame -> CGS, never DATA.
REQ-038 Assert rst_n low mid-ILAS (mcnt==2) -> all outputs zero asynchronously, CGS content after release.

Source files
------------

// File: rtl/jesd204b_tx_ctrl_if.sv
// ---------------------------------------------------------------------------
// jesd204b_tx_ctrl_if
// Frame-wide bus between the transport layer, the JESD204B link controller
// and the lane serialisers.
//   tpl_data   : transport-layer frame, lane i in [i*8*OCTETS +: 8*OCTETS],
//                octet 0 in the most significant byte of each lane
//   tpl_ready  : controller is consuming tpl_data this cycle
//   tx_data    : lane octets towards the PHY, same packing as tpl_data
//   tx_charisk : control-character flags, lane i in [i*OCTETS +: OCTETS],
//                octet 0 at the MSB of each lane
// Modports: master = link controller, slave = transport layer / PHY side.
// ---------------------------------------------------------------------------
interface jesd204b_tx_ctrl_if #(
    parameter int LANES  = 4,
    parameter int OCTETS = 4
);
    logic [LANES*8*OCTETS-1:0] tpl_data;
    logic                      tpl_ready;
    logic [LANES*8*OCTETS-1:0] tx_data;
    logic [LANES*OCTETS-1:0]   tx_charisk;

    modport master (
        input  tpl_data,
        output tpl_ready,
        output tx_data,
        output tx_charisk
    );

    modport slave (
        output tpl_data,
        input  tpl_ready,
        input  tx_data,
        input  tx_charisk
    );
endinterface

// File: rtl/jesd204b_tx_ctrl.sv
// ---------------------------------------------------------------------------
// jesd204b_tx_ctrl
// JESD204B transmit link-layer controller. Sequences the link through code
// group synchronisation (CGS), the initial lane alignment sequence (ILAS)
// and user data, driven by the receiver's SYNC~ request. One frame is
// produced per clock cycle.
// Ports:
//   clk        : frame clock
//   rst_n      : asynchronous active-low reset
//   sync_n     : SYNC~ from the receiver (asynchronous, low = resync)
//   bus        : tpl_data in, tpl_ready / tx_data / tx_charisk out
//   link_state : 0 = CGS, 1 = ILAS, 2 = DATA (direct view of state register)
//   lmfc       : one-cycle pulse marking frame 0 of each multiframe
// ---------------------------------------------------------------------------
module jesd204b_tx_ctrl #(
    parameter int LANES   = 4,
    parameter int OCTETS  = 4,
    parameter int FRAMES  = 32,
    parameter int ILAS_MF = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sync_n,
    jesd204b_tx_ctrl_if.master      bus,
    output logic [1:0]              link_state,
    output logic                    lmfc
);

    localparam int DW     = LANES * 8 * OCTETS;
    localparam int KW     = LANES * OCTETS;
    localparam int FCNT_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int MCNT_W = 4;

    localparam logic [FCNT_W-1:0] FLAST = FCNT_W'(FRAMES - 1);
    localparam logic [MCNT_W-1:0] MLAST = MCNT_W'(ILAS_MF - 1);

    localparam logic [7:0] K28_0 = 8'h1C;  // /R/ multiframe start
    localparam logic [7:0] K28_3 = 8'h7C;  // /A/ multiframe end
    localparam logic [7:0] K28_4 = 8'h9C;  // /Q/ config marker
    localparam logic [7:0] K28_5 = 8'hBC;  // /K/ code group sync

    typedef enum logic [1:0] {
        ST_CGS  = 2'd0,
        ST_ILAS = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                sync_meta_q, sync_meta_d;
    logic                sync_s_q, sync_s_d;
    logic                low_q, low_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic [MCNT_W-1:0]   mcnt_q, mcnt_d;
    logic                lmfc_q, lmfc_d;
    logic [DW-1:0]       tx_data_q, tx_data_d;
    logic [KW-1:0]       tx_charisk_q, tx_charisk_d;
    logic                tpl_ready_q, tpl_ready_d;

    logic                resync;
    logic [8*OCTETS-1:0] ilas_lane;
    logic [OCTETS-1:0]   ilas_lane_k;
    logic [7:0]          oct;
    logic                oct_k;

    // -----------------------------------------------------------------------
    // State register and counters
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_CGS;
            sync_meta_q  <= 1'b0;
            sync_s_q     <= 1'b0;
            low_q        <= 1'b0;
            fcnt_q       <= '0;
            mcnt_q       <= '0;
            lmfc_q       <= 1'b0;
            tx_data_q    <= '0;
            tx_charisk_q <= '0;
            tpl_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_meta_q  <= sync_meta_d;
            sync_s_q     <= sync_s_d;
            low_q        <= low_d;
            fcnt_q       <= fcnt_d;
            mcnt_q       <= mcnt_d;
            lmfc_q       <= lmfc_d;
            tx_data_q    <= tx_data_d;
            tx_charisk_q <= tx_charisk_d;
            tpl_ready_q  <= tpl_ready_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next state, counters, synchroniser
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        mcnt_d      = mcnt_q;
        low_d       = 1'b0;
        sync_meta_d = sync_n;
        sync_s_d    = sync_meta_q;
        fcnt_d      = (fcnt_q == FLAST) ? '0 : fcnt_q + FCNT_W'(1);
        lmfc_d      = (fcnt_q == '0);

        // Two consecutive synchronised lows drop the link; low_q remembers
        // the previous cycle so a single-cycle glitch is ignored.
        resync = (state_q != ST_CGS) && !sync_s_q && low_q;

        case (state_q)
            ST_CGS: begin
                mcnt_d = '0;
                if (sync_s_q && (fcnt_q == FLAST)) begin
                    state_d = ST_ILAS;
                end
            end
            ST_ILAS: begin
                low_d = !sync_s_q;
                if (fcnt_q == FLAST) begin
                    if (mcnt_q == MLAST) begin
                        state_d = ST_DATA;
                        mcnt_d  = '0;
                    end else begin
                        mcnt_d = mcnt_q + MCNT_W'(1);
                    end
                end
            end
            ST_DATA: begin
                low_d = !sync_s_q;
            end
            default: begin
                state_d = ST_CGS;
                mcnt_d  = '0;
            end
        endcase

        // Resync wins over the ILAS->DATA step in the same cycle.
        if (resync) begin
            state_d = ST_CGS;
            mcnt_d  = '0;
            low_d   = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Lane content, registered from the current state and frame position
    // -----------------------------------------------------------------------
    always_comb begin
        ilas_lane   = '0;
        ilas_lane_k = '0;
        oct         = 8'h00;
        oct_k       = 1'b0;

        // Every lane carries the same ILAS frame, so build one lane word.
        for (int o = 0; o < OCTETS; o++) begin
            oct   = 8'(int'(fcnt_q) * OCTETS + o);
            oct_k = 1'b0;
            if ((fcnt_q == '0) && (o == 0)) begin
                oct   = K28_0;
                oct_k = 1'b1;
            end else if ((fcnt_q == FLAST) && (o == OCTETS - 1)) begin
                oct   = K28_3;
                oct_k = 1'b1;
            end else if ((mcnt_q == MCNT_W'(1)) && (fcnt_q == '0) && (o == 1)) begin
                oct   = K28_4;
                oct_k = 1'b1;
            end
            ilas_lane[(OCTETS-1-o)*8 +: 8] = oct;
            ilas_lane_k[OCTETS-1-o]        = oct_k;
        end

        tx_data_d    = {KW{K28_5}};
        tx_charisk_d = '1;
        tpl_ready_d  = 1'b0;

        case (state_q)
            ST_ILAS: begin
                tx_data_d    = {LANES{ilas_lane}};
                tx_charisk_d = {LANES{ilas_lane_k}};
            end
            ST_DATA: begin
                tx_data_d    = bus.tpl_data;
                tx_charisk_d = '0;
                tpl_ready_d  = 1'b1;
            end
            default: begin
                tx_data_d    = {KW{K28_5}};
                tx_charisk_d = '1;
            end
        endcase
    end

    assign bus.tx_data    = tx_data_q;
    assign bus.tx_charisk = tx_charisk_q;
    assign bus.tpl_ready  = tpl_ready_q;
    assign link_state     = state_q;
    assign lmfc           = lmfc_q;

endmodule

// File: tb/tb_jesd204b_tx_ctrl.sv
module tb_jesd204b_tx_ctrl;

    localparam logic [127:0] BC_ALL = {16{8'hBC}};

    logic       clk;
    logic       rst_n;
    logic       sync_n;
    logic [1:0] link_state;
    logic       lmfc;

    int n_tests;
    int n_fail;
    int tb_f;

    jesd204b_tx_ctrl_if #(.LANES(4), .OCTETS(4)) bus ();

    jesd204b_tx_ctrl #(
        .LANES(4), .OCTETS(4), .FRAMES(32), .ILAS_MF(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sync_n     (sync_n),
        .bus        (bus),
        .link_state (link_state),
        .lmfc       (lmfc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference frame position: tracks the frame number of the current cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_f <= 0;
        else        tb_f <= (tb_f == 31) ? 0 : tb_f + 1;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_f(input int f);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tb_f != f && n < 64);
        if (tb_f != f) check("wait_frame_timeout", 128'(tb_f), 128'(f));
    endtask

    initial begin
        int lmfc_cnt;
        int bad_lmfc;
        int bad_cgs;
        int bad_state;
        logic [127:0] v;

        n_tests = 0;
        n_fail = 0;
        rst_n = 1'b0;
        sync_n = 1'b0;
        bus.tpl_data = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx_data", bus.tx_data, 128'h0);
        check("rst_charisk", 128'(bus.tx_charisk), 128'h0);
        check("rst_ready", 128'(bus.tpl_ready), 128'h0);
        check("rst_state", 128'(link_state), 128'h0);
        check("rst_lmfc", 128'(lmfc), 128'h0);

        // CGS with sync_n held low for 200 cycles
        rst_n = 1'b1;
        lmfc_cnt = 0; bad_lmfc = 0; bad_cgs = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("cgs_first_data", bus.tx_data, BC_ALL);
                check("cgs_first_k", 128'(bus.tx_charisk), 128'hFFFF);
            end
            if (lmfc) begin
                lmfc_cnt++;
                if (tb_f != 1) bad_lmfc++;
            end
            if (bus.tx_data !== BC_ALL || bus.tx_charisk !== 16'hFFFF || link_state !== 2'd0)
                bad_cgs++;
        end
        check("cgs_lmfc_count", 128'(lmfc_cnt), 128'd7);
        check("cgs_lmfc_align", 128'(bad_lmfc), 128'd0);
        check("cgs_hold", 128'(bad_cgs), 128'd0);

        // Sync request released at frame 5: ILAS from the next boundary
        wait_f(5);
        sync_n = 1'b1;
        wait_f(31);
        check("ilas_not_yet", 128'(link_state), 128'd0);
        wait_f(0);
        check("ilas_start", 128'(link_state), 128'd1);
        wait_f(1);
        check("ilas_r_data", bus.tx_data, {4{32'h1C010203}});
        check("ilas_r_k", 128'(bus.tx_charisk), 128'h8888);
        wait_f(0);
        check("ilas_a_data", bus.tx_data, {4{32'h7C7D7E7C}});
        check("ilas_a_k", 128'(bus.tx_charisk), 128'h1111);
        wait_f(1);
        check("ilas_q_data", bus.tx_data, {4{32'h1C9C0203}});
        check("ilas_q_k", 128'(bus.tx_charisk), 128'hCCCC);
        wait_f(11);
        check("ilas_mid_data", bus.tx_data, {4{32'h28292A2B}});
        check("ilas_mid_k", 128'(bus.tx_charisk), 128'h0);
        wait_f(0);
        wait_f(0);
        wait_f(31);
        check("ilas_last_frame", 128'(link_state), 128'd1);
        wait_f(0);
        check("data_start", 128'(link_state), 128'd2);
        check("data_start_k", 128'(bus.tx_charisk), 128'h1111);
        check("data_start_ready", 128'(bus.tpl_ready), 128'd0);

        // DATA passthrough with an incrementing 128-bit pattern
        for (int i = 0; i < 16; i++) begin
            v = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3200 + 128'(i);
            bus.tpl_data = v;
            @(negedge clk);
            check("data_pass", bus.tx_data, v);
        end
        check("data_ready", 128'(bus.tpl_ready), 128'd1);
        check("data_k", 128'(bus.tx_charisk), 128'h0);

        // Single-cycle sync glitch is ignored
        sync_n = 1'b0;
        @(negedge clk);
        sync_n = 1'b1;
        bad_state = 0;
        repeat (8) begin
            @(negedge clk);
            if (link_state !== 2'd2) bad_state++;
        end
        check("glitch_ignored", 128'(bad_state), 128'd0);

        // Two-cycle sync low: resync
        sync_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        sync_n = 1'b1;
        @(negedge clk);
        check("resync_before", 128'(link_state), 128'd2);
        @(negedge clk);
        check("resync_state", 128'(link_state), 128'd0);
        @(negedge clk);
        check("resync_data", bus.tx_data, BC_ALL);
        check("resync_k", 128'(bus.tx_charisk), 128'hFFFF);

        // Sync raised then dropped before the boundary: stay in CGS
        sync_n = 1'b0;
        bus.tpl_data = '0;
        repeat (40) @(negedge clk);
        check("cgs_settle", 128'(link_state), 128'd0);
        wait_f(10);
        sync_n = 1'b1;
        wait_f(20);
        sync_n = 1'b0;
        bad_state = 0;
        repeat (40) begin
            @(negedge clk);
            if (link_state !== 2'd0) bad_state++;
        end
        check("early_drop_cgs", 128'(bad_state), 128'd0);

        // Resync on the final ILAS frame beats the step to DATA
        sync_n = 1'b1;
        wait_f(31);
        wait_f(0);
        check("ilas2_start", 128'(link_state), 128'd1);
        repeat (96) @(negedge clk);
        wait_f(28);
        sync_n = 1'b0;
        wait_f(30);
        sync_n = 1'b1;
        wait_f(31);
        check("ilas2_last", 128'(link_state), 128'd1);
        wait_f(0);
        check("ilas2_abort", 128'(link_state), 128'd0);
        bad_state = 0;
        repeat (31) begin
            @(negedge clk);
            if (link_state !== 2'd0) bad_state++;
        end
        check("ilas2_never_data", 128'(bad_state), 128'd0);

        // Reset in the middle of ILAS (third multiframe)
        wait_f(0);
        check("ilas3_start", 128'(link_state), 128'd1);
        repeat (64 + 5) @(negedge clk);
        check("ilas3_mid", 128'(link_state), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_data", bus.tx_data, 128'h0);
        check("arst_k", 128'(bus.tx_charisk), 128'h0);
        check("arst_state", 128'(link_state), 128'd0);
        check("arst_ready", 128'(bus.tpl_ready), 128'd0);
        check("arst_lmfc", 128'(lmfc), 128'd0);
        sync_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_data", bus.tx_data, BC_ALL);
        check("post_rst_k", 128'(bus.tx_charisk), 128'hFFFF);
        check("post_rst_state", 128'(link_state), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
